// File: rtl/divsqrt_rr_scheduler_pkg.sv
// Shared widths, rounding-mode encodings and index helpers for the divSqrt round-robin scheduler.
// Pure declarations: no logic and no latency.
package divsqrt_rr_scheduler_pkg;

  localparam int EXC_W = 5;
  localparam int RM_W  = 3;

  typedef enum logic [RM_W-1:0] {
    RM_NEAR_EVEN   = 3'd0,
    RM_MIN_MAG     = 3'd1,
    RM_MIN         = 3'd2,
    RM_MAX         = 3'd3,
    RM_NEAR_MAXMAG = 3'd4,
    RM_ODD         = 3'd6
  } rm_e;

  function automatic int rec_width(input int exp_w, input int sig_w);
    return exp_w + sig_w + 1;
  endfunction

  // Explicit wrap so non-power-of-2 requester counts never reach an invalid index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/divsqrt_rr_arb.sv
// Round-robin pick of the first eligible requester at or after rr_ptr.
// Combinational, zero latency; an all-zero grant means nothing is eligible.
module divsqrt_rr_arb #(
  parameter int N  = 4,
  parameter int TW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [TW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [TW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [TW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = TW'((int'(rr_ptr) + k) % N);
      if (!grant_vld && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divsqrt_rr_scheduler.sv
// Shares one divSqrt unit among numReq requesters, one op in flight, results steered by tag to 1-entry buffers.
// Result visible one cycle after du_outValid; a requester with an unconsumed result is never granted.
module divsqrt_rr_scheduler
  import divsqrt_rr_scheduler_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int numReq   = 4,
  localparam int RW = rec_width(expWidth, sigWidth),
  localparam int TW = $clog2(numReq)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [numReq-1:0]       req_valid,
  output logic [numReq-1:0]       req_ready,
  input  logic [numReq-1:0]       req_sqrtOp,
  input  logic [numReq*RW-1:0]    req_a,
  input  logic [numReq*RW-1:0]    req_b,
  input  logic [numReq*RM_W-1:0]  req_rm,
  output logic [numReq-1:0]       resp_valid,
  input  logic [numReq-1:0]       resp_ready,
  output logic [numReq*RW-1:0]    resp_out,
  output logic [numReq*EXC_W-1:0] resp_exc,
  output logic [numReq-1:0]       resp_sqrtOp,
  output logic                    du_inValid,
  input  logic                    du_inReady,
  output logic                    du_sqrtOp,
  output logic [RW-1:0]           du_a,
  output logic [RW-1:0]           du_b,
  output logic [RM_W-1:0]         du_rm,
  input  logic                    du_outValid,
  input  logic [RW-1:0]           du_out,
  input  logic [EXC_W-1:0]        du_exc,
  input  logic                    du_sqrtOpOut,
  output logic                    busy
);

  logic              busy_q, busy_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic [TW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [numReq-1:0] resp_full_q, resp_full_d;
  logic [numReq-1:0] eligible, grant;
  logic [TW-1:0]     grant_idx;
  logic              grant_vld, issue, complete;

  assign eligible = req_valid & ~resp_full_q;

  divsqrt_rr_arb #(.N(numReq), .TW(TW)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    du_inValid = ~reset & ~busy_q & grant_vld;
    issue      = du_inValid & du_inReady;
    complete   = du_outValid & busy_q;
    req_ready  = grant & {numReq{~reset & ~busy_q & du_inReady}};

    du_sqrtOp = 1'b0;
    du_a      = '0;
    du_b      = '0;
    du_rm     = '0;
    if (grant_vld) begin
      du_sqrtOp = req_sqrtOp[grant_idx];
      du_a      = req_a[grant_idx*RW +: RW];
      du_b      = req_b[grant_idx*RW +: RW];
      du_rm     = req_rm[grant_idx*RM_W +: RM_W];
    end

    busy_d   = busy_q;
    tag_d    = tag_q;
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      busy_d   = 1'b1;
      tag_d    = grant_idx;
      rr_ptr_d = TW'(wrap_inc(int'(grant_idx), numReq));
    end else if (complete) begin
      busy_d = 1'b0;
    end

    // The completing slot was empty at issue, so fill never races a drain.
    resp_full_d = resp_full_q & ~resp_ready;
    if (complete) begin
      resp_full_d[tag_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      tag_q       <= '0;
      rr_ptr_q    <= '0;
      resp_full_q <= '0;
    end else begin
      busy_q      <= busy_d;
      tag_q       <= tag_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_full_q <= resp_full_d;
    end
  end

  for (genvar i = 0; i < numReq; i++) begin : g_resp
    logic             fill;
    logic [RW-1:0]    out_q, out_d;
    logic [EXC_W-1:0] exc_q, exc_d;
    logic             sq_q, sq_d;

    always_comb begin
      fill  = complete && (tag_q == TW'(i));
      out_d = fill ? du_out       : out_q;
      exc_d = fill ? du_exc       : exc_q;
      sq_d  = fill ? du_sqrtOpOut : sq_q;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        out_q <= '0;
        exc_q <= '0;
        sq_q  <= 1'b0;
      end else begin
        out_q <= out_d;
        exc_q <= exc_d;
        sq_q  <= sq_d;
      end
    end

    assign resp_out[i*RW +: RW]       = out_q;
    assign resp_exc[i*EXC_W +: EXC_W] = exc_q;
    assign resp_sqrtOp[i]             = sq_q;
  end

  assign resp_valid = resp_full_q;
  assign busy       = busy_q;

  // A completion with nothing in flight means the unit missed a reset.
  assert property (@(posedge clock) disable iff (reset) !(du_outValid && !busy_q));

endmodule

// File: tb/tb_divsqrt_rr_scheduler.sv
// Bench for divsqrt_rr_scheduler with a behavioural divSqrt stand-in and a cycle-level scoreboard.
module tb_divsqrt_rr_scheduler;
  import divsqrt_rr_scheduler_pkg::*;

  localparam int NR = 4;
  localparam int TW = 2;
  localparam int RW = 33;
  localparam int EW = 5;
  localparam logic [RW-1:0] REC_0   = 33'h000000000;
  localparam logic [RW-1:0] REC_1   = 33'h080000000;
  localparam logic [RW-1:0] REC_2   = 33'h080800000;
  localparam logic [RW-1:0] REC_4   = 33'h081000000;
  localparam logic [RW-1:0] REC_INF = 33'h0C0000000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0]    req_valid, req_ready, req_sqrtOp, resp_valid, resp_ready, resp_sqrtOp;
  logic [NR*RW-1:0] req_a, req_b, resp_out;
  logic [NR*3-1:0]  req_rm;
  logic [NR*EW-1:0] resp_exc;
  logic             du_inValid, du_inReady, du_sqrtOp, du_outValid, du_sqrtOpOut, busy;
  logic [RW-1:0]    du_a, du_b, du_out;
  logic [2:0]       du_rm;
  logic [EW-1:0]    du_exc;

  int n_chk = 0;
  int n_err = 0;

  divsqrt_rr_scheduler dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sqrtOp(req_sqrtOp),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
    .resp_exc(resp_exc), .resp_sqrtOp(resp_sqrtOp),
    .du_inValid(du_inValid), .du_inReady(du_inReady), .du_sqrtOp(du_sqrtOp),
    .du_a(du_a), .du_b(du_b), .du_rm(du_rm),
    .du_outValid(du_outValid), .du_out(du_out), .du_exc(du_exc),
    .du_sqrtOpOut(du_sqrtOpOut), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Stand-in for divSqrtRecFN: exact for the directed operands, a fixed scramble otherwise.
  function automatic logic [37:0] unit_fn(input logic sq, input logic [RW-1:0] a,
                                          input logic [RW-1:0] b, input logic [2:0] rm);
    if (sq) begin
      if (a == REC_4) return {REC_2, 5'b00000};
      return {a ^ {30'b0, rm}, {2'b00, rm}};
    end
    if (b[31:29] == 3'b000) return {a[32] ^ b[32], REC_INF[31:0], 5'b01000};
    return {a ^ {b[31:0], b[32]}, {2'b10, rm}};
  endfunction

  logic        mu_busy, mu_sq, ready_en;
  int          mu_cnt, lat_force;
  logic [37:0] mu_res;

  assign du_inReady = ~mu_busy & ready_en;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mu_busy <= 1'b0; mu_cnt <= 0; mu_res <= '0; mu_sq <= 1'b0;
      du_outValid <= 1'b0; du_out <= '0; du_exc <= '0; du_sqrtOpOut <= 1'b0;
    end else begin
      du_outValid <= 1'b0;
      if (du_inValid && du_inReady) begin
        mu_busy <= 1'b1;
        mu_cnt  <= (lat_force != 0) ? lat_force : int'($urandom_range(0, 4));
        mu_res  <= unit_fn(du_sqrtOp, du_a, du_b, du_rm);
        mu_sq   <= du_sqrtOp;
      end else if (mu_busy) begin
        if (mu_cnt == 0) begin
          du_outValid  <= 1'b1;
          du_out       <= mu_res[37:5];
          du_exc       <= mu_res[4:0];
          du_sqrtOpOut <= mu_sq;
          mu_busy      <= 1'b0;
        end else begin
          mu_cnt <= mu_cnt - 1;
        end
      end
    end
  end

  // Scoreboard: expected state per the scheduling rules, compared every falling edge.
  bit            m_busy, any, e_inv;
  logic [TW-1:0] m_tag, idx, g;
  int            m_ptr;
  logic [NR-1:0] m_full, e_rdy;
  logic [37:0]   m_res [NR];
  logic          m_rsq [NR];
  logic [37:0]   m_pend;
  logic          m_pend_sq;

  always @(negedge clock) begin
    if (reset) begin
      m_busy = 0; m_tag = '0; m_ptr = 0; m_full = '0;
    end
    any = 0; g = '0;
    for (int k = 0; k < NR; k++) begin
      idx = TW'((m_ptr + k) % NR);
      if (!any && req_valid[idx] && !m_full[idx]) begin any = 1; g = idx; end
    end
    e_inv = !reset && !m_busy && any;
    e_rdy = (e_inv && du_inReady) ? NR'(1 << g) : '0;
    chk("du_inValid", 64'(du_inValid), 64'(e_inv));
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("resp_valid", 64'(resp_valid), 64'(m_full));
    if (e_inv) begin
      chk("du_a", 64'(du_a), 64'(req_a[g*RW +: RW]));
      chk("du_b", 64'(du_b), 64'(req_b[g*RW +: RW]));
      chk("du_rm", 64'(du_rm), 64'(req_rm[g*3 +: 3]));
      chk("du_sqrtOp", 64'(du_sqrtOp), 64'(req_sqrtOp[g]));
    end
    for (int i = 0; i < NR; i++) begin
      if (m_full[i]) begin
        chk("resp_out", 64'(resp_out[i*RW +: RW]), 64'(m_res[i][37:5]));
        chk("resp_exc", 64'(resp_exc[i*EW +: EW]), 64'(m_res[i][4:0]));
        chk("resp_sqrtOp", 64'(resp_sqrtOp[i]), 64'(m_rsq[i]));
      end
    end
    if (!reset) begin
      for (int i = 0; i < NR; i++) if (m_full[i] && resp_ready[i]) m_full[i] = 1'b0;
      if (e_inv && du_inReady) begin
        m_busy = 1; m_tag = g; m_ptr = (int'(g) + 1) % NR;
        m_pend = unit_fn(req_sqrtOp[g], req_a[g*RW +: RW], req_b[g*RW +: RW], req_rm[g*3 +: 3]);
        m_pend_sq = req_sqrtOp[g];
      end else if (du_outValid && m_busy) begin
        m_full[m_tag] = 1'b1; m_res[m_tag] = m_pend; m_rsq[m_tag] = m_pend_sq; m_busy = 0;
      end
    end
  end

  // Stimulus side
  int            dut_grants[$];
  int            gcnt [NR];
  logic [NR-1:0] keep;

  task automatic set_req(input int i, input logic sq, input logic [RW-1:0] a,
                         input logic [RW-1:0] b, input logic [2:0] rm);
    req_valid[i] = 1'b1;
    req_sqrtOp[i] = sq;
    req_a[i*RW +: RW] = a;
    req_b[i*RW +: RW] = b;
    req_rm[i*3 +: 3] = rm;
  endtask

  task automatic rand_req(input int i);
    logic [RW-1:0] a, b;
    a = {1'($urandom_range(0, 1)), 32'($urandom)};
    b = ($urandom_range(0, 3) == 0) ? REC_0 : {1'($urandom_range(0, 1)), 32'($urandom)};
    set_req(i, 1'($urandom_range(0, 1)), a, b, 3'($urandom_range(0, 4)));
  endtask

  task automatic cyc();
    logic [NR-1:0] acc;
    @(negedge clock);
    acc = req_ready & req_valid;
    for (int i = 0; i < NR; i++) if (acc[i]) begin dut_grants.push_back(i); gcnt[i]++; end
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        if (keep[i]) rand_req(i);
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; keep = '0; lat_force = 0;
    cyc(); cyc();
    reset = 1'b0;
    dut_grants.delete();
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
  endtask

  task automatic wait_resp(input int i, input string name);
    int n = 0;
    while (!resp_valid[i] && n < 200) begin cyc(); n++; end
    chk(name, 64'(resp_valid[i]), 64'd1);
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((req_valid != '0 || busy || resp_valid != '0) && n < 400) begin cyc(); n++; end
    chk(name, 64'({req_valid, busy, resp_valid}), 64'd0);
  endtask

  initial begin
    req_valid = '0; req_sqrtOp = '0; req_a = '0; req_b = '0; req_rm = '0;
    resp_ready = '0; ready_en = 1'b1; keep = '0; lat_force = 0;
    for (int i = 0; i < NR; i++) gcnt[i] = 0;

    // Reset state with every requester asking
    for (int i = 0; i < NR; i++) rand_req(i);
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_du_inValid", 64'(du_inValid), 64'd0);
    do_reset();

    // Single sqrt(4.0) on requester 2
    set_req(2, 1'b1, REC_4, REC_0, RM_NEAR_EVEN);
    wait_resp(2, "t1_wait");
    chk("t1_out", 64'(resp_out[2*RW +: RW]), 64'(REC_2));
    chk("t1_exc", 64'(resp_exc[2*EW +: EW]), 64'd0);
    chk("t1_only_resp2", 64'(resp_valid), 64'b0100);
    resp_ready = 4'hF;
    wait_quiet("t1_drain");

    // Continuous requests: strict rotation
    do_reset();
    resp_ready = 4'hF; keep = 4'hF;
    for (int i = 0; i < NR; i++) rand_req(i);
    begin
      int n = 0;
      while (dut_grants.size() < 8 && n < 300) begin cyc(); n++; end
    end
    chk("t2_count", 64'(dut_grants.size() >= 8), 64'd1);
    for (int k = 0; k < 8 && k < dut_grants.size(); k++)
      chk("t2_order", 64'(dut_grants[k]), 64'(k % NR));
    keep = '0;
    wait_quiet("t2_drain");

    // Requester 1 never consumes: granted once, then blocked
    do_reset();
    resp_ready = 4'b1101; keep = 4'hF;
    for (int i = 0; i < NR; i++) rand_req(i);
    repeat (60) cyc();
    chk("t3_req1_once", 64'(gcnt[1]), 64'd1);
    chk("t3_others_served", 64'(gcnt[0] > 2 && gcnt[2] > 2 && gcnt[3] > 2), 64'd1);
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
    resp_ready[1] = 1'b1;
    cyc();
    resp_ready[1] = 1'b0;
    repeat (30) cyc();
    chk("t3_req1_after_consume", 64'(gcnt[1]), 64'd1);
    keep = '0; resp_ready = 4'hF;
    wait_quiet("t3_drain");

    // 1.0 / 0.0 on requester 3
    do_reset();
    set_req(3, 1'b0, REC_1, REC_0, RM_NEAR_EVEN);
    wait_resp(3, "t4_wait");
    chk("t4_out", 64'(resp_out[3*RW +: RW]), 64'(REC_INF));
    chk("t4_exc", 64'(resp_exc[3*EW +: EW]), 64'b01000);
    chk("t4_only_resp3", 64'(resp_valid), 64'b1000);
    resp_ready = 4'hF;
    wait_quiet("t4_drain");

    // Reset in the middle of a long divide
    do_reset();
    lat_force = 10;
    set_req(1, 1'b0, REC_4, REC_2, RM_MIN);
    begin
      int n = 0;
      while (!busy && n < 50) begin cyc(); n++; end
    end
    chk("t5_busy", 64'(busy), 64'd1);
    repeat (3) cyc();
    reset = 1'b1; req_valid = '0;
    @(negedge clock);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_resp", 64'(resp_valid), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0; lat_force = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("t5_no_stale", 64'(resp_valid), 64'd0);
    end
    set_req(0, 1'b1, REC_4, REC_0, RM_NEAR_EVEN);
    wait_resp(0, "t5_new_wait");
    chk("t5_new_out", 64'(resp_out[0 +: RW]), 64'(REC_2));
    wait_quiet("t5_drain");

    // Pointer at 3, only requester 0 eligible, then pointer must sit at 1
    do_reset();
    rand_req(2);
    wait_quiet("t6_setup");
    dut_grants.delete();
    rand_req(0);
    wait_quiet("t6_wrap");
    chk("t6_wrap_count", 64'(dut_grants.size()), 64'd1);
    if (dut_grants.size() > 0) chk("t6_wrap_grant", 64'(dut_grants[0]), 64'd0);
    dut_grants.delete();
    rand_req(0); rand_req(1); rand_req(3);
    wait_quiet("t6_after");
    chk("t6_count", 64'(dut_grants.size()), 64'd3);
    if (dut_grants.size() == 3) begin
      chk("t6_first", 64'(dut_grants[0]), 64'd1);
      chk("t6_second", 64'(dut_grants[1]), 64'd3);
      chk("t6_third", 64'(dut_grants[2]), 64'd0);
    end

    // Random traffic with consumer and unit backpressure
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
      resp_ready = NR'($urandom);
      ready_en = ($urandom_range(0, 3) != 0);
      cyc();
    end
    resp_ready = 4'hF; ready_en = 1'b1;
    wait_quiet("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
